// File: rtl/div_pkg.sv
// Shared types and constants for the divider request queue.
// Operands are unsigned 4-bit; a zero divisor is replaced before it reaches the divider.
package div_pkg;

    localparam int OPERAND_W = 4;
    localparam logic [OPERAND_W-1:0] DBZ_QUOTIENT = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [OPERAND_W-1:0] dividend;
        logic [OPERAND_W-1:0] divisor;
    } req_t;

    function automatic logic [OPERAND_W-1:0] safe_divisor(input logic [OPERAND_W-1:0] d);
        return (d == '0) ? OPERAND_W'(1) : d;
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Small synchronous FIFO holding dividend/divisor requests.
// Head entry is always visible on rdata; storage itself is not reset.
module div_req_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   occupancy
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign rdata     = mem_q[rd_ptr_q];
    assign occupancy = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/div_request_queue.sv
// Feeds queued dividend/divisor pairs to an external combinational divider
// and registers each result into a valid/ready output stage.
//
// state | meaning
// IDLE  | waiting for a queued request; operands mirror the FIFO head
// ISSUE | operands registered, divider settles; result captured at end
// HOLD  | result presented on out_*, waiting for out_ready
module div_request_queue
    import div_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPERAND_W-1:0] in_dividend,
    input  logic [OPERAND_W-1:0] in_divisor,
    output logic [OPERAND_W-1:0] div_dividend,
    output logic [OPERAND_W-1:0] div_divisor,
    input  logic [OPERAND_W-1:0] div_quotient,
    input  logic [OPERAND_W-1:0] div_remainder,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPERAND_W-1:0] out_quotient,
    output logic [OPERAND_W-1:0] out_remainder,
    output logic                 out_dbz,
    output logic [PTR_W:0]       occupancy
);

    localparam int REQ_W = $bits(req_t);

    req_t                 in_req;
    req_t                 head;
    logic [REQ_W-1:0]     head_bits;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    state_e               state_q, state_d;
    logic [OPERAND_W-1:0] op_dividend_q, op_dividend_d;
    logic [OPERAND_W-1:0] op_divisor_q, op_divisor_d;
    logic                 op_dbz_q, op_dbz_d;
    logic                 out_valid_q, out_valid_d;
    logic [OPERAND_W-1:0] out_quotient_q, out_quotient_d;
    logic [OPERAND_W-1:0] out_remainder_q, out_remainder_d;
    logic                 out_dbz_q, out_dbz_d;

    assign in_req.dividend = in_dividend;
    assign in_req.divisor  = in_divisor;
    assign head            = head_bits;

    // in_ready looks only at the registered count, never at out_ready.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    div_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .wdata     (in_req),
        .pop       (pop),
        .rdata     (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    always_comb begin
        state_d         = state_q;
        op_dividend_d   = op_dividend_q;
        op_divisor_d    = op_divisor_q;
        op_dbz_d        = op_dbz_q;
        out_valid_d     = out_valid_q;
        out_quotient_d  = out_quotient_q;
        out_remainder_d = out_remainder_q;
        out_dbz_d       = out_dbz_q;
        pop             = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d       = ISSUE;
                    op_dividend_d = head.dividend;
                    op_divisor_d  = safe_divisor(head.divisor);
                    op_dbz_d      = (head.divisor == '0);
                end
            end
            ISSUE: begin
                state_d         = HOLD;
                pop             = 1'b1;
                out_valid_d     = 1'b1;
                out_quotient_d  = op_dbz_q ? DBZ_QUOTIENT : div_quotient;
                out_remainder_d = op_dbz_q ? op_dividend_q : div_remainder;
                out_dbz_d       = op_dbz_q;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        state_d       = ISSUE;
                        op_dividend_d = head.dividend;
                        op_divisor_d  = safe_divisor(head.divisor);
                        op_dbz_d      = (head.divisor == '0);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            op_dividend_q   <= '0;
            op_divisor_q    <= OPERAND_W'(1);
            op_dbz_q        <= 1'b0;
            out_valid_q     <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
            out_dbz_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_dividend_q   <= op_dividend_d;
            op_divisor_q    <= op_divisor_d;
            op_dbz_q        <= op_dbz_d;
            out_valid_q     <= out_valid_d;
            out_quotient_q  <= out_quotient_d;
            out_remainder_q <= out_remainder_d;
            out_dbz_q       <= out_dbz_d;
        end
    end

    // While idle the divider already sees the head, with a zero divisor masked.
    always_comb begin
        if ((state_q == IDLE) && !fifo_empty) begin
            div_dividend = head.dividend;
            div_divisor  = safe_divisor(head.divisor);
        end else begin
            div_dividend = op_dividend_q;
            div_divisor  = op_divisor_q;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign out_dbz       = out_dbz_q;

endmodule

// File: tb/tb_div_request_queue.sv
// Self-checking bench for div_request_queue: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_div_request_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [3:0]       in_dividend = 4'd0;
    logic [3:0]       in_divisor = 4'd0;
    logic             in_ready;
    logic [3:0]       div_dividend, div_divisor, div_quotient, div_remainder;
    logic             out_valid, out_dbz;
    logic [3:0]       out_quotient, out_remainder;
    logic [PTR_W:0]   occupancy;

    always #5 clk = ~clk;

    // Stand-in for the external combinational divider.
    assign div_quotient  = (div_divisor == 4'd0) ? 4'd0 : div_dividend / div_divisor;
    assign div_remainder = (div_divisor == 4'd0) ? div_dividend : div_dividend % div_divisor;

    div_request_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_dbz       (out_dbz),
        .occupancy     (occupancy)
    );

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        int         cyc;
    } res_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
    } vec_t;

    res_t exp_q[$];
    res_t hs_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    bit   last_fire_in = 1'b0;
    bit   started = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic res_t model(input logic [3:0] a, input logic [3:0] b);
        res_t r;
        r.cyc = 0;
        if (b == 4'd0) begin
            r.q = 4'hF; r.r = a; r.dbz = 1'b1;
        end else begin
            r.q = a / b; r.r = a % b; r.dbz = 1'b0;
        end
        return r;
    endfunction

    // One clock: score handshakes due at this edge, then check afterwards.
    task automatic tick();
        bit   fire_out, stalled;
        res_t snap, e;
        last_fire_in = rst_n && in_valid && in_ready;
        fire_out     = rst_n && out_valid && out_ready;
        stalled      = rst_n && out_valid && !out_ready;
        snap.q = out_quotient; snap.r = out_remainder; snap.dbz = out_dbz; snap.cyc = cycle;
        if (fire_out) begin
            hs_log.push_back(snap);
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_quotient", int'(out_quotient), int'(e.q));
                chk("sb_remainder", int'(out_remainder), int'(e.r));
                chk("sb_dbz", int'(out_dbz), int'(e.dbz));
            end
        end
        if (last_fire_in) exp_q.push_back(model(in_dividend, in_divisor));
        @(posedge clk);
        #1;
        cycle++;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (stalled) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_quotient", int'(out_quotient), int'(snap.q));
                chk("stall_remainder", int'(out_remainder), int'(snap.r));
                chk("stall_dbz", int'(out_dbz), int'(snap.dbz));
            end
            chk("in_ready_vs_occupancy", int'(in_ready), int'(occupancy != DEPTH));
        end
    endtask

    task automatic push_one(input logic [3:0] a, input logic [3:0] b, input int max_cyc, output bit acc);
        in_dividend = a;
        in_divisor  = b;
        in_valid    = 1'b1;
        acc         = 1'b0;
        for (int i = 0; i < max_cyc && !acc; i++) begin
            tick();
            acc = last_fire_in;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((out_valid || occupancy != 0) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_done", int'(out_valid || occupancy != 0), 0);
    endtask

    task automatic single(input vec_t v);
        in_dividend = v.a;
        in_divisor  = v.b;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_accept", int'(last_fire_in), 1);
        chk("single_occ_after_push", int'(occupancy), 1);
        chk("single_valid_n", int'(out_valid), 0);
        tick();
        chk("issue_dividend", int'(div_dividend), int'(v.a));
        chk("issue_divisor", int'(div_divisor), (v.b == 4'd0) ? 1 : int'(v.b));
        chk("single_valid_n1", int'(out_valid), 0);
        tick();
        chk("latency_valid_n2", int'(out_valid), 1);
        chk("vec_quotient", int'(out_quotient), int'(v.q));
        chk("vec_remainder", int'(out_remainder), int'(v.r));
        chk("vec_dbz", int'(out_dbz), int'(v.dbz));
        chk("single_occ_after_pop", int'(occupancy), 0);
        tick();
        chk("single_valid_cleared", int'(out_valid), 0);
    endtask

    always @(negedge clk) begin
        if (started && rst_n) chk("div_divisor_nonzero", int'(div_divisor != 4'd0), 1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        logic [3:0] fa[6];
        logic [3:0] fb[6];
        logic [3:0] ba[4];
        logic [3:0] bb[4];
        logic [3:0] bq[4];
        logic [3:0] br[4];
        bit acc;
        int n;
        vec_t v63;

        vecs[0]  = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1,  dbz: 1'b0};
        vecs[1]  = '{a: 4'd9,  b: 4'd0,  q: 4'hF,  r: 4'd9,  dbz: 1'b1};
        vecs[2]  = '{a: 4'd15, b: 4'd5,  q: 4'd3,  r: 4'd0,  dbz: 1'b0};
        vecs[3]  = '{a: 4'd0,  b: 4'd0,  q: 4'hF,  r: 4'd0,  dbz: 1'b1};
        vecs[4]  = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0,  dbz: 1'b0};
        vecs[5]  = '{a: 4'd7,  b: 4'd2,  q: 4'd3,  r: 4'd1,  dbz: 1'b0};
        vecs[6]  = '{a: 4'd8,  b: 4'd8,  q: 4'd1,  r: 4'd0,  dbz: 1'b0};
        vecs[7]  = '{a: 4'd0,  b: 4'd3,  q: 4'd0,  r: 4'd0,  dbz: 1'b0};
        vecs[8]  = '{a: 4'd1,  b: 4'd15, q: 4'd0,  r: 4'd1,  dbz: 1'b0};
        vecs[9]  = '{a: 4'd15, b: 4'd0,  q: 4'hF,  r: 4'd15, dbz: 1'b1};
        vecs[10] = '{a: 4'd14, b: 4'd3,  q: 4'd4,  r: 4'd2,  dbz: 1'b0};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        started = 1'b1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quotient", int'(out_quotient), 0);
        chk("rst_remainder", int'(out_remainder), 0);
        chk("rst_dbz", int'(out_dbz), 0);
        chk("rst_div_dividend", int'(div_dividend), 0);
        chk("rst_div_divisor", int'(div_divisor), 1);

        for (int i = 0; i < 11; i++) single(vecs[i]);

        // Fill to full with the output stalled
        hs_log.delete();
        fa[0] = 4'd15; fa[1] = 4'd1; fa[2] = 4'd2; fa[3] = 4'd3; fa[4] = 4'd4; fa[5] = 4'd5;
        fb[0] = 4'd5;  fb[1] = 4'd1; fb[2] = 4'd1; fb[3] = 4'd1; fb[4] = 4'd1; fb[5] = 4'd2;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_one(fa[k], fb[k], 1, acc);
            chk("fill_accept", int'(acc), 1);
        end
        chk("full_occupancy", int'(occupancy), 4);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_out_valid", int'(out_valid), 1);
        in_dividend = fa[5];
        in_divisor  = fb[5];
        in_valid    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("full_held_off", int'(last_fire_in), 0);
            chk("full_occ_stall", int'(occupancy), 4);
            chk("stall_first_quotient", int'(out_quotient), 3);
            chk("stall_first_remainder", int'(out_remainder), 0);
        end
        // Release output while full: pop lands on the ISSUE->HOLD edge
        out_ready = 1'b1;
        tick();
        chk("full_release_no_push", int'(last_fire_in), 0);
        chk("full_release_occ", int'(occupancy), 4);
        tick();
        chk("full_pop_no_push", int'(last_fire_in), 0);
        chk("full_pop_occ", int'(occupancy), 3);
        chk("full_pop_in_ready", int'(in_ready), 1);
        tick();
        chk("full_late_push", int'(last_fire_in), 1);
        in_valid = 1'b0;
        drain();
        chk("fill_result_count", hs_log.size(), 6);
        if (hs_log.size() == 6) begin
            chk("fill_last_quotient", int'(hs_log[5].q), 2);
            chk("fill_last_remainder", int'(hs_log[5].r), 1);
        end

        // Back-to-back drain
        hs_log.delete();
        ba[0] = 4'd15; ba[1] = 4'd7; ba[2] = 4'd8; ba[3] = 4'd0;
        bb[0] = 4'd1;  bb[1] = 4'd2; bb[2] = 4'd8; bb[3] = 4'd3;
        bq[0] = 4'd15; bq[1] = 4'd3; bq[2] = 4'd1; bq[3] = 4'd0;
        br[0] = 4'd0;  br[1] = 4'd1; br[2] = 4'd0; br[3] = 4'd0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_one(ba[k], bb[k], 4, acc);
            chk("b2b_accept", int'(acc), 1);
        end
        out_ready = 1'b1;
        n = 0;
        while (hs_log.size() < 4 && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_result_count", hs_log.size(), 4);
        if (hs_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("b2b_quotient", int'(hs_log[k].q), int'(bq[k]));
                chk("b2b_remainder", int'(hs_log[k].r), int'(br[k]));
                if (k > 0) chk("b2b_spacing", hs_log[k].cyc - hs_log[k-1].cyc, 2);
            end
        end
        drain();

        // Reset while holding a result with two entries queued
        out_ready = 1'b0;
        for (int k = 1; k < 4; k++) begin
            push_one(fa[k], fb[k], 4, acc);
            chk("hold_accept", int'(acc), 1);
        end
        chk("hold_valid_before_rst", int'(out_valid), 1);
        chk("hold_occ_before_rst", int'(occupancy), 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_occupancy", int'(occupancy), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        v63 = '{a: 4'd6, b: 4'd3, q: 4'd2, r: 4'd0, dbz: 1'b0};
        single(v63);

        // Random traffic against the reference queue
        for (int k = 0; k < 400; k++) begin
            in_valid    = ($urandom_range(0, 9) < 6);
            in_dividend = 4'($urandom_range(0, 15));
            in_divisor  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            out_ready   = ($urandom_range(0, 1) == 1);
            tick();
        end
        drain();
        chk("sb_empty_at_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
